// File: rtl/micro_sequencer.sv
// Microcode sequencer: next-address select (increment/jump/dispatch/return)
// with an optional return stack, built only when MICRO_SEQUENCER_STACK_EN is defined.
module micro_sequencer #(
  parameter int unsigned UADDR_W = 8,
  parameter int unsigned STACK_D = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         next_sel,
  input  logic [UADDR_W-1:0] target,
  input  logic [5:0]         op,
  input  logic               br_cond,
  input  logic               cond,
  input  logic               call,
  output logic [UADDR_W-1:0] upc,
  output logic [3:0]         sp,
  output logic               stack_ovf,
  output logic               stack_unf
);

  localparam int unsigned SP_W = 4;
  localparam logic [1:0] SEL_INC  = 2'd0;
  localparam logic [1:0] SEL_JUMP = 2'd1;
  localparam logic [1:0] SEL_DISP = 2'd2;
  localparam logic [1:0] SEL_RET  = 2'd3;

  logic [UADDR_W-1:0] upc_inc_c;
  logic [UADDR_W-1:0] dispatch_c;
  logic [UADDR_W-1:0] upc_nxt_c;
  logic               jump_taken_c;

  // Candidate addresses shared by both build variants
  always_comb begin
    upc_inc_c    = upc + UADDR_W'(1);
    dispatch_c   = UADDR_W'({2'b01, op});
    jump_taken_c = (next_sel == SEL_JUMP) && (!br_cond || cond);
  end

`ifdef MICRO_SEQUENCER_STACK_EN
  localparam int unsigned IDX_W = $clog2(STACK_D);

  logic [UADDR_W-1:0] stack_mem [STACK_D];
  logic [IDX_W-1:0]   push_idx_c;
  logic [IDX_W-1:0]   top_idx_c;
  logic               stack_full_c;
  logic               stack_empty_c;
  logic               push_c;
  logic [SP_W-1:0]    sp_nxt_c;
  logic               ovf_nxt_c;
  logic               unf_nxt_c;

  // Next-address and stack-pointer selection
  always_comb begin
    stack_full_c  = (sp == SP_W'(STACK_D));
    stack_empty_c = (sp == '0);
    push_idx_c    = IDX_W'(sp);
    top_idx_c     = IDX_W'(sp - SP_W'(1));
    push_c        = 1'b0;
    upc_nxt_c     = upc_inc_c;
    sp_nxt_c      = sp;
    ovf_nxt_c     = stack_ovf;
    unf_nxt_c     = stack_unf;
    case (next_sel)
      SEL_JUMP: begin
        if (jump_taken_c) begin
          upc_nxt_c = target;
          if (call) begin
            if (stack_full_c) begin
              ovf_nxt_c = 1'b1;
            end else begin
              push_c   = 1'b1;
              sp_nxt_c = sp + SP_W'(1);
            end
          end
        end
      end
      SEL_DISP: upc_nxt_c = dispatch_c;
      SEL_RET: begin
        if (stack_empty_c) begin
          upc_nxt_c = '0;
          unf_nxt_c = 1'b1;
        end else begin
          upc_nxt_c = stack_mem[top_idx_c];
          sp_nxt_c  = sp - SP_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Stack storage is not reset; entries above sp are never read
  always_ff @(posedge clk) begin
    if (en && push_c) begin
      stack_mem[push_idx_c] <= upc_inc_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (en) begin
      sp        <= sp_nxt_c;
      stack_ovf <= ovf_nxt_c;
      stack_unf <= unf_nxt_c;
    end
  end
`else
  logic unused_call;
  assign unused_call = call;

  // Without a stack, call is ignored and a return restarts at address 0
  always_comb begin
    upc_nxt_c = upc_inc_c;
    case (next_sel)
      SEL_JUMP: if (jump_taken_c) upc_nxt_c = target;
      SEL_DISP: upc_nxt_c = dispatch_c;
      SEL_RET:  upc_nxt_c = '0;
      default: ;
    endcase
  end

  assign sp        = '0;
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc <= '0;
    end else if (en) begin
      upc <= upc_nxt_c;
    end
  end

endmodule
